// File: rtl/log_pkg.sv
// Shared definitions for the logging capture buffer: default widths,
// buffer depth and the write-side controller state encoding.
package log_pkg;

  localparam int unsigned LOG_ADDR_W = 10;
  localparam int unsigned LOG_DATA_W = 10;
  localparam int unsigned LOG_DEPTH  = 1 << LOG_ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    DONE
  } state_t;

endpackage

// File: rtl/log_capture_writer.sv
// Write-side controller: trigger-centred circular capture into the sample RAM,
// reporting the captured window (start/trigger address, done) to the reader.
module log_capture_writer
  import log_pkg::*;
#(
  parameter int unsigned ADDR_W = LOG_ADDR_W,
  parameter int unsigned DATA_W = LOG_DATA_W
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              trigger,
  input  logic              samp_valid,
  input  logic [DATA_W-1:0] samp_data,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [ADDR_W-1:0] post_len,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              wen,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] trig_addr
);

  state_t            state;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] pre_lat;
  logic [ADDR_W-1:0] post_lat;
  logic [ADDR_W:0]   cfg_sum;
  logic [ADDR_W-1:0] post_clamped;

  // Window must fit the buffer: max post = (2**ADDR_W - 1) - pre = ~pre.
  always_comb begin
    cfg_sum      = {1'b0, pre_len} + {1'b0, post_len};
    post_clamped = post_len;
    if (cfg_sum > {1'b0, {ADDR_W{1'b1}}}) post_clamped = ~pre_len;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wptr       <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      pre_lat    <= '0;
      post_lat   <= '0;
      waddr      <= '0;
      wdata      <= '0;
      wen        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      start_addr <= '0;
      trig_addr  <= '0;
    end else begin
      wen <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (arm) begin
              state    <= PRE;
              busy     <= 1'b1;
              done     <= 1'b0;
              wptr     <= '0;
              pre_cnt  <= '0;
              pre_lat  <= pre_len;
              post_lat <= post_clamped;
            end
          end
          PRE: begin
            if (pre_lat == '0) begin
              state <= WAIT_TRIG;
            end else if (samp_valid) begin
              waddr   <= wptr;
              wdata   <= samp_data;
              wen     <= 1'b1;
              wptr    <= wptr + ADDR_W'(1);
              pre_cnt <= pre_cnt + ADDR_W'(1);
              // Leave on the last pre sample so the next sample is not lost.
              if (pre_cnt + ADDR_W'(1) == pre_lat) state <= WAIT_TRIG;
            end
          end
          WAIT_TRIG: begin
            if (samp_valid) begin
              waddr <= wptr;
              wdata <= samp_data;
              wen   <= 1'b1;
              wptr  <= wptr + ADDR_W'(1);
              if (trigger) begin
                trig_addr  <= wptr;
                start_addr <= wptr - pre_lat;
                post_cnt   <= '0;
                if (post_lat == '0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  state <= POST;
                end
              end
            end
          end
          POST: begin
            if (samp_valid) begin
              waddr    <= wptr;
              wdata    <= samp_data;
              wen      <= 1'b1;
              wptr     <= wptr + ADDR_W'(1);
              post_cnt <= post_cnt + ADDR_W'(1);
              if (post_cnt + ADDR_W'(1) == post_lat) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/log_capture_writer.md
Name: log_capture_writer

Overview:
- Write-side controller for the logging capture buffer.
- Accepts a 10-bit sample stream and runs a trigger-centred capture into the 1024x10 dual-port sample RAM.
- The RAM is treated as a circular buffer, with a programmable pre-trigger depth and post-trigger length.
- Drives the RAM write port (waddr/wdata/wen) on the RAM's write clock and reports the capture window (start address, trigger address, done) to the read-side logic.

Parameters:
- ADDR_W, 10, RAM address width; buffer depth = 2**ADDR_W.
- DATA_W, 10, sample and RAM data width.

Ports:
- clk_in  input  1  write-domain clock (same clock as the RAM write port)
- rst  input  1  reset, asynchronous, active-high
- arm  input  1  start a capture; honoured only in IDLE or DONE
- abort  input  1  cancel the capture; return to IDLE from any state
- trigger  input  1  trigger event; qualified by samp_valid
- samp_valid  input  1  sample strobe
- samp_data  input  DATA_W  sample value
- pre_len  input  ADDR_W  number of samples to keep before the trigger sample
- post_len  input  ADDR_W  number of samples to keep after the trigger sample
- waddr  output  ADDR_W  RAM write address
- wdata  output  DATA_W  RAM write data
- wen  output  1  RAM write enable
- busy  output  1  high in PRE, WAIT_TRIG and POST
- done  output  1  capture complete; held until the next arm or abort
- start_addr  output  ADDR_W  address of the oldest captured sample
- trig_addr  output  ADDR_W  address of the trigger sample

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; waddr, wdata, wen, busy, done, start_addr and trig_addr all 0; internal pointer and counters 0.
- Output registration: all outputs are registered. A sample accepted at edge N appears on wen/waddr/wdata during cycle N+1 (latency 1). wen pulses exactly once per accepted sample.
- Config latch on arm:
  - pre_len and post_len are latched when arm is taken.
  - If pre_len + post_len > 2**ADDR_W - 1, the latched post_len is clamped to (2**ADDR_W - 1 - pre_len).
  - Later changes to the inputs are ignored until the next arm.
- IDLE:
  - wen = 0, samples are dropped.
  - arm -> PRE; on entry: wptr = 0, pre_cnt = 0, done = 0.
- PRE:
  - Each samp_valid writes samp_data at wptr; wptr increments modulo 2**ADDR_W; pre_cnt increments.
  - trigger is ignored in this state.
  - When pre_cnt reaches the latched pre_len -> WAIT_TRIG. With pre_len = 0, PRE exits after one cycle without writing anything.
- WAIT_TRIG:
  - samp_valid without trigger: write and advance wptr; the buffer wraps freely.
  - samp_valid with trigger: the sample is the trigger sample. It is written, trig_addr = wptr, start_addr = (wptr - pre_len) mod 2**ADDR_W, post_cnt = 0, next state POST.
  - trigger without samp_valid has no effect.
- POST:
  - Each samp_valid writes and increments post_cnt. trigger is ignored.
  - When post_cnt reaches the latched post_len -> DONE.
  - With post_len = 0, the state goes straight to DONE on the cycle after the trigger sample.
- DONE:
  - done = 1, busy = 0, no writes.
  - start_addr and trig_addr hold their values.
  - arm -> PRE (done clears).
- abort:
  - From any state -> IDLE on the next edge; no further writes. A write already registered for the current cycle still completes.
  - done clears; start_addr and trig_addr hold.
  - abort and arm in the same cycle: abort wins.
- arm while busy: ignored.
- Captured window: pre_len + 1 + post_len samples ending at (trig_addr + post_len) mod 2**ADDR_W; the read side starts at start_addr.

Decomposition:
- Shared package log_pkg:
  - ADDR_W and DATA_W defaults.
  - State encoding enum: IDLE, PRE, WAIT_TRIG, POST, DONE.
  - Buffer depth constant.
- Single module; no sub-module is warranted. The pointer/counter logic is simple enough to live inline.

Test Plan:
- Reset mid-capture: assert rst asynchronously while in POST -> all outputs 0 immediately, state IDLE, no wen after release.
- Basic capture: pre_len = 4, post_len = 3, arm, stream values 1..20 with trigger on value 9 -> the writes shown below, done = 1 afterwards.
  - Writes 1..8 at addresses 0..7; trigger sample 9 at address 8; post samples 10..12 at 9..11.
  - trig_addr = 8, start_addr = 4.
- Wrap-around: pre_len = 8, post_len = 8, 1030 samples before the trigger -> expected results below.
  - wptr wraps 1023 -> 0.
  - trig_addr = 1030 mod 1024 = 6; start_addr = 1022; RAM words 1022..1023 and 0..14 hold the window.
- Zero lengths: pre_len = 0, post_len = 0, arm, trigger on the first valid sample (value 0x155) -> single write 0x155 at address 0, trig_addr = start_addr = 0, done on the following cycle.
- Clamp, abort and arm rules:
  - pre_len = 1000, post_len = 100 -> post phase writes exactly 23 samples.
  - abort together with arm in DONE -> IDLE, done = 0.
  - arm during POST -> ignored, capture completes normally.
